// File: rtl/uart_pkg.sv
// Shared UART definitions: MMIO offsets, RX status bit positions and receiver state encoding.
package uart_pkg;

    localparam logic [15:0] MMIO_TX_OFS        = 16'h0100;
    localparam logic [15:0] MMIO_RX_DATA_OFS   = 16'h0104;
    localparam logic [15:0] MMIO_RX_STATUS_OFS = 16'h0108;

    localparam int ST_NONEMPTY_BIT  = 0;
    localparam int ST_FULL_BIT      = 1;
    localparam int ST_FRAME_ERR_BIT = 2;
    localparam int ST_OVERRUN_BIT   = 3;

    // DATA read on an empty receiver: bit 8 flags "no byte"
    localparam logic [31:0] RX_EMPTY_WORD = 32'h0000_0100;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO of 2^DEPTH_LOG entries; a push into a full FIFO is accepted when a pop
// happens in the same cycle, otherwise it is dropped and reported on `drop`.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == (DEPTH_LOG + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem_q[rd_ptr_q];

    // NOTE: every signal assigned in always_comb gets its default first, so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with one-cycle MMIO read return. Define UART_RX_MMIO_FIFO_EN
// for a 2^FIFO_DEPTH_LOG-entry byte FIFO; otherwise a single holding register is used.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int SERIAL_WCNT    = 120,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        oe,
    input  logic [15:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        nonempty
);

    localparam int CNT_W = $clog2(SERIAL_WCNT);

    rx_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       sync1_q, sync2_q;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic [31:0] rdata_q, rdata_d;
    logic       valid_q;
    logic       push, frame_err_set, pop, status_rd, cnt_zero;
    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty, fifo_drop;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            RX_IDLE: if (!sync2_q) begin
                state_d = RX_START;
                bit_d   = '0;
                cnt_d   = CNT_W'(SERIAL_WCNT / 2 - 1);
            end
            RX_START: if (!cnt_zero) begin
                cnt_d = cnt_q - 1'b1;
            end else if (sync2_q) begin
                state_d = RX_IDLE;
            end else begin
                state_d = RX_DATA;
                cnt_d   = CNT_W'(SERIAL_WCNT - 1);
            end
            RX_DATA: if (!cnt_zero) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                cnt_d   = CNT_W'(SERIAL_WCNT - 1);
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (!cnt_zero) begin
                cnt_d = cnt_q - 1'b1;
            end else if (sync2_q) begin
                push    = 1'b1;
                state_d = RX_IDLE;
            end else begin
                frame_err_set = 1'b1;
                state_d       = RX_WAIT_IDLE;
            end
            RX_WAIT_IDLE: if (sync2_q) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

`ifdef UART_RX_MMIO_FIFO_EN
    uart_rx_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );
`else
    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_byte_q, hold_byte_d;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_byte_d = hold_byte_q;
        fifo_drop   = 1'b0;
        if (push && (!hold_full_q || pop)) begin
            hold_byte_d = shift_q;
            hold_full_d = 1'b1;
        end else if (push) begin
            fifo_drop = 1'b1;
        end else if (pop) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_byte_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_byte_q <= hold_byte_d;
        end
    end

    assign fifo_rdata = hold_byte_q;
    assign fifo_full  = hold_full_q;
    assign fifo_empty = !hold_full_q;
`endif

    assign pop       = oe && (addr == MMIO_RX_DATA_OFS) && !fifo_empty;
    assign status_rd = oe && (addr == MMIO_RX_STATUS_OFS);

    // Flag set events outrank the clear-on-read of STATUS in the same cycle.
    always_comb begin
        frame_err_d = frame_err_set || (frame_err_q && !status_rd);
        overrun_d   = fifo_drop || (overrun_q && !status_rd);
        rdata_d     = '0;
        if (oe) begin
            case (addr)
                MMIO_RX_DATA_OFS:
                    rdata_d = fifo_empty ? RX_EMPTY_WORD : {24'h0, fifo_rdata};
                MMIO_RX_STATUS_OFS: begin
                    rdata_d[ST_NONEMPTY_BIT]  = !fifo_empty;
                    rdata_d[ST_FULL_BIT]      = fifo_full;
                    rdata_d[ST_FRAME_ERR_BIT] = frame_err_q;
                    rdata_d[ST_OVERRUN_BIT]   = overrun_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rdata_q     <= rdata_d;
            valid_q     <= oe;
        end
    end

    assign rdata    = rdata_q;
    assign valid    = valid_q;
    assign nonempty = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio at SERIAL_WCNT=8; adapts the expected depth to UART_RX_MMIO_FIFO_EN.
module tb_uart_rx_mmio;
    import uart_pkg::*;

    localparam int WCNT = 8;
    localparam int DLOG = 4;
`ifdef UART_RX_MMIO_FIFO_EN
    localparam int DEPTH = 1 << DLOG;
`else
    localparam int DEPTH = 1;
`endif
    // A single-entry receiver reports full together with nonempty.
    localparam logic [31:0] ST_ONE_BYTE = (DEPTH == 1) ? 32'h3 : 32'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        oe = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] rdata;
    logic        valid;
    logic        nonempty;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_mmio #(.SERIAL_WCNT(WCNT), .FIFO_DEPTH_LOG(DLOG)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .oe       (oe),
        .addr     (addr),
        .rdata    (rdata),
        .valid    (valid),
        .nonempty (nonempty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got rdata 0x%08h, expected no response", rdata);
            end else begin
                check("read_rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [15:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        oe   = 1'b1;
        addr = a;
        exp_q.push_back(exp);
    endtask

    task automatic rd_done();
        @(posedge clk);
        #1;
        oe   = 1'b0;
        addr = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic rd1(input logic [15:0] a, input logic [31:0] exp);
        rd(a, exp);
        rd_done();
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rxd = frame[i];
            repeat (WCNT - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [7:0] partial;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_nonempty", {31'h0, nonempty}, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Single clean byte, unmapped offsets have no side effect
        send_byte(8'hA5, 1'b1);
        #1 check("nonempty_after_a5", {31'h0, nonempty}, 32'h1);
        rd1(16'h0000, 32'h0);
        rd1(MMIO_TX_OFS, 32'h0);
        rd1(MMIO_RX_STATUS_OFS, ST_ONE_BYTE);
        rd1(MMIO_RX_DATA_OFS, 32'h0000_00A5);
        rd1(MMIO_RX_DATA_OFS, RX_EMPTY_WORD);
        #1 check("nonempty_after_pop", {31'h0, nonempty}, 32'h0);

        // Overrun: one byte more than the buffer holds, no reads in between
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1);
        rd(MMIO_RX_STATUS_OFS, 32'h0000_000B);
        for (int i = 0; i < DEPTH; i++) rd(MMIO_RX_DATA_OFS, 32'(i));
        rd(MMIO_RX_STATUS_OFS, 32'h0);
        rd(MMIO_RX_DATA_OFS, RX_EMPTY_WORD);
        rd_done();

        // Framing error, then recovery with a clean byte
        send_byte(8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        rd1(MMIO_RX_STATUS_OFS, 32'h0000_0004);
        rd(MMIO_RX_STATUS_OFS, 32'h0);
        rd(MMIO_RX_DATA_OFS, RX_EMPTY_WORD);
        rd_done();
        send_byte(8'h5A, 1'b1);
        rd1(MMIO_RX_DATA_OFS, 32'h0000_005A);

        // Two-cycle low glitch must be rejected
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        rd(MMIO_RX_STATUS_OFS, 32'h0);
        rd(MMIO_RX_DATA_OFS, RX_EMPTY_WORD);
        rd_done();

        // Full buffer: a pop coinciding with the push edge makes room (no overrun)
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b1);
        rd1(MMIO_RX_STATUS_OFS, 32'h3);
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (78) @(posedge clk);
                rd(MMIO_RX_DATA_OFS, 32'h40);
                rd_done();
            end
        join
        rd(MMIO_RX_STATUS_OFS, 32'h3);
        for (int i = 1; i < DEPTH; i++) rd(MMIO_RX_DATA_OFS, 32'h40 + 32'(i));
        rd(MMIO_RX_DATA_OFS, 32'h55);
        rd(MMIO_RX_STATUS_OFS, 32'h0);
        rd_done();

        // Reset during bit 4 of a frame with a byte already buffered
        send_byte(8'h11, 1'b1);
        #1 check("nonempty_before_rst", {31'h0, nonempty}, 32'h1);
        partial = 8'h99;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (WCNT - 1) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 rxd = partial[i];
            repeat ((i == 4) ? 3 : WCNT - 1) @(posedge clk);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_rst_rdata", rdata, 32'h0);
        check("midframe_rst_valid", {31'h0, valid}, 32'h0);
        check("midframe_rst_nonempty", {31'h0, nonempty}, 32'h0);
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        rd1(MMIO_RX_STATUS_OFS, 32'h0);
        send_byte(8'h7E, 1'b1);
        rd(MMIO_RX_DATA_OFS, 32'h0000_007E);
        rd(MMIO_RX_DATA_OFS, RX_EMPTY_WORD);
        rd_done();

        repeat (4) @(posedge clk);
        check("pending_reads", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
